// File: rtl/phase_sequencer_if.sv
// Bus between the phase sequencer and the datapath: control requests in,
// phase enables and debug status out.
interface phase_sequencer_if #(
    parameter int NUM_PHASES = 5,
    parameter int PHASE_W    = 3,
    parameter int CNT_W      = 16
);
    logic                  exec;
    logic                  step_mode;
    logic                  stall;
    logic                  halt;
    logic                  register_reset;
    logic [PHASE_W-1:0]    phase;
    logic [NUM_PHASES-1:0] phase_en;
    logic                  running;
    logic                  halted;
    logic                  instr_done;
    logic [CNT_W-1:0]      instr_count;

    modport master (
        input  exec, step_mode, stall, halt,
        output register_reset, phase, phase_en, running, halted,
               instr_done, instr_count
    );

    modport slave (
        output exec, step_mode, stall, halt,
        input  register_reset, phase, phase_en, running, halted,
               instr_done, instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer: walks the phase counter, issues one-hot
// phase enables and handles run/pause, single-step, stall and halt.
module phase_sequencer #(
    parameter int NUM_PHASES = 5,
    parameter int PHASE_W    = 3,
    parameter int CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    phase_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    state_t                state_q, state_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  done_q, done_d;
    logic                  exec_q;

    logic                  exec_rise;
    logic                  running;
    logic                  adv;
    logic                  wrap;
    logic                  retire;
    logic [NUM_PHASES-1:0] phase_en;

    assign exec_rise = bus.exec & ~exec_q;
    assign running   = (state_q == RUN) || (state_q == STEP);
    assign adv       = running & ~bus.stall;
    assign wrap      = adv && (phase_q == LAST_PHASE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            exec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            done_q  <= done_d;
            exec_q  <= bus.exec;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        done_d  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                // phase is held here, so a resume continues mid-instruction
                if (exec_rise) state_d = bus.step_mode ? STEP : RUN;
            end
            RUN: begin
                // halt at the boundary takes priority over a pause request
                if (wrap && bus.halt) begin
                    retire  = 1'b1;
                    state_d = HALTED;
                end else if (exec_rise) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    retire = 1'b1;
                end else if (adv) begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            STEP: begin
                if (wrap) begin
                    retire  = 1'b1;
                    state_d = bus.halt ? HALTED : IDLE;
                end else if (adv) begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (retire) begin
            phase_d = '0;
            count_d = count_q + CNT_W'(1);
            done_d  = 1'b1;
        end
    end

    always_comb begin
        phase_en = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            phase_en[i] = adv && (phase_q == PHASE_W'(i));
        end
    end

    assign bus.register_reset = reset;
    assign bus.phase          = phase_q;
    assign bus.phase_en       = phase_en;
    assign bus.running        = running;
    assign bus.halted         = (state_q == HALTED);
    assign bus.instr_done     = done_q;
    assign bus.instr_count    = count_q;

endmodule
